// File: rtl/beat_pkg.sv
// Shared definitions for the beat sequencer: key code width, FSM encoding,
// and the layout of one recorded event.
package beat_pkg;
  localparam int KEY_W = 7;
  localparam logic [KEY_W-1:0] SILENCE = 7'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_REC, S_FLUSH, S_PLOAD, S_POUT, S_DONE
  } state_t;

  // Event entry is {key[KEY_W-1:0], dur[dur_w-1:0]} with the key in the upper bits.
  function automatic int entry_w(input int dur_w);
    return KEY_W + dur_w;
  endfunction
endpackage

// File: rtl/event_ram.sv
// Single-port event store: synchronous write-first RAM, one-cycle read latency,
// contents are not reset.
module event_ram
  import beat_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = entry_w(12)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/beat_sequencer.sv
// Records the live key stream as (key, duration-in-ticks) events and replays
// them as a registered 7-bit key code for the tone generator.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 500000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [KEY_W-1:0]     ascii_in,
  input  logic                 record_en,
  input  logic                 play_en,
  input  logic                 clear,
  output logic [KEY_W-1:0]     ascii_out,
  output logic                 recording,
  output logic                 playing,
  output logic                 full,
  output logic [$clog2(DEPTH):0] count,
  output logic                 done
);
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int EW     = entry_w(DUR_W);
  localparam int TW     = $clog2(TICK_DIV);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic                 tick, tick_clr;
  logic [KEY_W-1:0]     cur_key, cur_key_n, ascii_n;
  logic [DUR_W-1:0]     dur, dur_n, d_inc, rem, rem_n;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, count_n;
  logic                 done_n, rd_vld, rd_vld_n, play_blk, play_blk_n;
  logic                 we;
  logic [EW-1:0]        wdata, rdata;
  logic [AW-1:0]        addr;

  assign tick      = (tick_cnt == TICK_LAST);
  assign d_inc     = dur + DUR_W'(tick);
  assign recording = (state == S_REC) || (state == S_FLUSH);
  assign playing   = (state == S_PLOAD) || (state == S_POUT);
  assign full      = (count == DEPTH_P);
  assign addr      = recording ? wr_ptr[AW-1:0] : rd_ptr[AW-1:0];

  event_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always_comb begin
    state_n    = state;
    cur_key_n  = cur_key;
    dur_n      = dur;
    rem_n      = rem;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    ascii_n    = ascii_out;
    done_n     = 1'b0;
    rd_vld_n   = 1'b0;
    // a finished playback stays locked out until play_en is released
    play_blk_n = play_blk & play_en;
    tick_clr   = 1'b0;
    we         = 1'b0;
    wdata      = {cur_key, d_inc};

    case (state)
      S_IDLE: begin
        if (clear) begin
          count_n = '0;
        end else if (record_en && !full) begin
          wr_ptr_n  = count;
          cur_key_n = ascii_in;
          dur_n     = '0;
          tick_clr  = 1'b1;
          state_n   = S_REC;
        end else if (play_en && !play_blk) begin
          rd_ptr_n = '0;
          tick_clr = 1'b1;
          state_n  = S_PLOAD;
        end
      end

      S_REC: begin
        if (!record_en) begin
          dur_n   = d_inc;
          state_n = S_FLUSH;
        end else if (ascii_in != cur_key) begin
          // a key held for less than one tick is dropped, not written
          we        = (d_inc != '0);
          cur_key_n = ascii_in;
          dur_n     = '0;
        end else if (d_inc == DUR_MAX) begin
          we    = 1'b1;
          dur_n = '0;
        end else begin
          dur_n = d_inc;
        end
        if (we) begin
          count_n  = count + PTR_W'(1);
          wr_ptr_n = wr_ptr + PTR_W'(1);
          if (count_n == DEPTH_P) state_n = S_IDLE;
        end
      end

      S_FLUSH: begin
        wdata = {cur_key, dur};
        if (dur != '0 && !full) begin
          we       = 1'b1;
          count_n  = count + PTR_W'(1);
          wr_ptr_n = wr_ptr + PTR_W'(1);
        end
        dur_n   = '0;
        state_n = S_IDLE;
      end

      S_PLOAD: begin
        if (!rd_vld) begin
          if (rd_ptr == count) begin
            state_n    = S_DONE;
            ascii_n    = SILENCE;
            done_n     = 1'b1;
            play_blk_n = 1'b1;
          end else begin
            rd_vld_n = 1'b1;
          end
        end else begin
          ascii_n = rdata[EW-1 -: KEY_W];
          rem_n   = rdata[DUR_W-1:0];
          state_n = S_POUT;
        end
      end

      S_POUT: begin
        if (!play_en) begin
          ascii_n = SILENCE;
          state_n = S_IDLE;
        end else if (tick) begin
          rem_n = rem - DUR_W'(1);
          if (rem <= DUR_W'(1)) begin
            rem_n    = '0;
            rd_ptr_n = rd_ptr + PTR_W'(1);
            state_n  = S_PLOAD;
          end
        end
      end

      S_DONE: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    tick_cnt_n = (tick || tick_clr) ? '0 : tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      cur_key   <= SILENCE;
      dur       <= '0;
      rem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ascii_out <= SILENCE;
      done      <= 1'b0;
      rd_vld    <= 1'b0;
      play_blk  <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      cur_key   <= cur_key_n;
      dur       <= dur_n;
      rem       <= rem_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      ascii_out <= ascii_n;
      done      <= done_n;
      rd_vld    <= rd_vld_n;
      play_blk  <= play_blk_n;
    end
  end
endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with DEPTH=4, DUR_W=3, TICK_DIV=4:
// one tick is 4 clk and a duration saturates at 7 ticks.
module tb_beat_sequencer;
  localparam int DEPTH = 4, DUR_W = 3, TICK_DIV = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [6:0]    ascii_in = '0;
  logic          record_en = 1'b0, play_en = 1'b0, clear = 1'b0;
  logic [6:0]    ascii_out;
  logic          recording, playing, full, done;
  logic [CW-1:0] count;

  int nvec = 0, nerr = 0;

  beat_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .resetn(resetn), .ascii_in(ascii_in), .record_en(record_en),
    .play_en(play_en), .clear(clear), .ascii_out(ascii_out),
    .recording(recording), .playing(playing), .full(full), .count(count),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance n clock edges, then settle 1 ns past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1 resetn = 1'b0;
    #2;
    chk("rst_ascii", 32'(ascii_out), 0);
    chk("rst_rec",   32'(recording), 0);
    chk("rst_play",  32'(playing), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done",  32'(done), 0);
    @(posedge clk); #1 resetn = 1'b1;
    cyc(1);

    // record 65 for 3 ticks, 83 for 2 ticks, then silence
    ascii_in = 7'd65; record_en = 1'b1; cyc(1);
    chk("rec_active", 32'(recording), 1);
    cyc(12);
    chk("rec_cnt0", 32'(count), 0);
    ascii_in = 7'd83; cyc(1);
    chk("rec_cnt1", 32'(count), 1);
    cyc(7);
    ascii_in = 7'd0; cyc(1);
    record_en = 1'b0; cyc(1);
    chk("flush_rec", 32'(recording), 1);
    cyc(1);
    chk("rec_idle", 32'(recording), 0);
    chk("rec_count", 32'(count), 2);

    // play back: 2-cycle load, 65 held 12 clk incl. next load, 83, then done
    play_en = 1'b1;
    for (int t = 0; t < 23; t++) begin
      cyc(1);
      chk("play_key",  32'(ascii_out), (t < 2) ? 0 : (t < 14) ? 65 : (t < 21) ? 83 : 0);
      chk("play_done", 32'(done), 32'(t == 21));
    end
    cyc(2);
    chk("no_loop", 32'(playing), 0);
    play_en = 1'b0; cyc(1);

    // abort playback mid-event
    play_en = 1'b1; cyc(6);
    chk("abort_pre", 32'(ascii_out), 65);
    play_en = 1'b0; cyc(1);
    chk("abort_key",  32'(ascii_out), 0);
    chk("abort_play", 32'(playing), 0);
    for (int t = 0; t < 4; t++) begin
      chk("abort_done", 32'(done), 0);
      cyc(1);
    end

    // asynchronous reset during output
    play_en = 1'b1; cyc(5);
    chk("rstp_pre", 32'(ascii_out), 65);
    #2 resetn = 1'b0;
    #1;
    chk("rstp_ascii", 32'(ascii_out), 0);
    chk("rstp_play",  32'(playing), 0);
    chk("rstp_count", 32'(count), 0);
    play_en = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    cyc(1);

    // empty playback
    play_en = 1'b1; cyc(1);
    chk("empty_pload", 32'(playing), 1);
    chk("empty_d0",    32'(done), 0);
    cyc(1);
    chk("empty_done",  32'(done), 1);
    chk("empty_ascii", 32'(ascii_out), 0);
    cyc(1);
    chk("empty_d2", 32'(done), 0);
    play_en = 1'b0; cyc(1);

    // glitch: 66 lasts under a tick, clear in REC is ignored
    ascii_in = 7'd65; record_en = 1'b1; cyc(5);
    ascii_in = 7'd66; cyc(1);
    chk("glitch_c1", 32'(count), 1);
    ascii_in = 7'd67; clear = 1'b1; cyc(1);
    clear = 1'b0;
    chk("glitch_c2", 32'(count), 1);
    cyc(2);
    record_en = 1'b0; cyc(2);
    chk("glitch_cnt", 32'(count), 2);
    ascii_in = 7'd0;
    play_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cyc(1);
      chk("glitch_key",  32'(ascii_out), (t < 2) ? 0 : (t < 6) ? 65 : (t < 9) ? 67 : 0);
      chk("glitch_done", 32'(done), 32'(t == 9));
    end
    play_en = 1'b0; cyc(1);
    clear = 1'b1; cyc(1);
    clear = 1'b0;
    chk("clear_idle", 32'(count), 0);

    // saturation: 10 ticks of 68 splits into 7 + 3
    ascii_in = 7'd68; record_en = 1'b1; cyc(1);
    cyc(28);
    chk("sat_c1", 32'(count), 1);
    cyc(12);
    record_en = 1'b0; cyc(2);
    chk("sat_cnt", 32'(count), 2);
    ascii_in = 7'd0;
    play_en = 1'b1;
    for (int t = 0; t < 43; t++) begin
      cyc(1);
      chk("sat_key",  32'(ascii_out), (t < 2) ? 0 : (t < 41) ? 68 : 0);
      chk("sat_done", 32'(done), 32'(t == 41));
    end
    play_en = 1'b0; cyc(1);
    clear = 1'b1; cyc(1);
    clear = 1'b0;

    // full: four 1-tick events fill memory, fifth key is not stored
    ascii_in = 7'd65; record_en = 1'b1; cyc(1);
    for (int k = 1; k <= 4; k++) begin
      cyc(4);
      ascii_in = (k % 2 == 1) ? 7'd83 : 7'd65;
    end
    cyc(1);
    chk("full_flag",  32'(full), 1);
    chk("full_count", 32'(count), 4);
    chk("full_idle",  32'(recording), 0);
    ascii_in = 7'd83; cyc(4);
    chk("full_hold",  32'(count), 4);
    chk("full_norec", 32'(recording), 0);
    record_en = 1'b0; cyc(1);
    clear = 1'b1; cyc(1);
    clear = 1'b0;
    chk("full_clr_cnt",  32'(count), 0);
    chk("full_clr_flag", 32'(full), 0);

    // record and play requested together: record wins
    ascii_in = 7'd0; record_en = 1'b1; play_en = 1'b1; cyc(1);
    chk("both_rec",  32'(recording), 1);
    chk("both_play", 32'(playing), 0);
    record_en = 1'b0; play_en = 1'b0; cyc(3);
    chk("both_idle", 32'(recording), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
